// File: rtl/crc_master_pkg.sv
// Shared constants and FSM state type for the CRC peripheral bus master.
package crc_master_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned WAS_BIT  = 25;
  localparam int unsigned TCRC_BIT = 24;
  localparam int unsigned FXOR_BIT = 26;

  localparam logic [BUS_W-1:0] ADDR_DATA = 32'h4003_2000;
  localparam logic [BUS_W-1:0] ADDR_POLY = 32'h4003_2004;
  localparam logic [BUS_W-1:0] ADDR_CTRL = 32'h4003_2008;
  localparam logic [BUS_W-1:0] WAS_MASK  = 32'h1 << WAS_BIT;

  typedef enum logic [2:0] {
    IDLE, CTRL_SEED, POLY, SEED, CTRL_RUN, DATA, READ, FIN
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; only built with CRC_MASTER_FIFO_EN.
`ifdef CRC_MASTER_FIFO_EN
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push on full is still taken
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule
`endif

// File: rtl/crc_stream_master.sv
// Sequences one CRC job onto the peripheral bus: program ctrl/poly/seed, stream words, read result.
// Optional input buffering is compiled in with CRC_MASTER_FIFO_EN.
module crc_stream_master
  import crc_master_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_ctrl,
  input  logic [31:0]      cfg_poly,
  input  logic [31:0]      cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             Sel,
  output logic             RW,
  output logic [31:0]      addr,
  output logic [31:0]      data_wr,
  input  logic [31:0]      data_rd,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [31:0]      ctrl_q, poly_q, seed_q;
  logic             sel_n, rw_n, busy_n, done_n;
  logic [31:0]      addr_n, wdata_n;
  logic             take;
  logic             avail;
  logic [31:0]      word;
  logic             unused_cfg;

  // constants that only matter to the peripheral or to the buffered build
  assign unused_cfg = ^{32'(DEPTH), 32'(TCRC_BIT), 32'(FXOR_BIT)};

`ifdef CRC_MASTER_FIFO_EN
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_dout;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (take),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !rst && !fifo_full;
  assign avail    = !fifo_empty;
  assign word     = fifo_dout;
`else
  // words are taken one cycle ahead of their registered bus write
  assign in_ready = ((state == CTRL_RUN) || (state == DATA)) && (rem != '0);
  assign avail    = in_valid;
  assign word     = in_data;
`endif

  // next state plus the bus transaction to present next cycle
  always_comb begin
    state_n = state;
    rem_n   = rem;
    sel_n   = 1'b0;
    rw_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    busy_n  = busy;
    done_n  = 1'b0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CTRL_SEED;
          rem_n   = cfg_len;
          busy_n  = 1'b1;
          sel_n   = 1'b1;
          rw_n    = 1'b1;
          addr_n  = ADDR_CTRL;
          wdata_n = cfg_ctrl | WAS_MASK;
        end
      end
      CTRL_SEED: begin
        state_n = POLY;
        sel_n   = 1'b1;
        rw_n    = 1'b1;
        addr_n  = ADDR_POLY;
        wdata_n = poly_q;
      end
      POLY: begin
        state_n = SEED;
        sel_n   = 1'b1;
        rw_n    = 1'b1;
        addr_n  = ADDR_DATA;
        wdata_n = seed_q;
      end
      SEED: begin
        state_n = CTRL_RUN;
        sel_n   = 1'b1;
        rw_n    = 1'b1;
        addr_n  = ADDR_CTRL;
        wdata_n = ctrl_q & ~WAS_MASK;
      end
      CTRL_RUN, DATA: begin
        if (rem == '0) begin
          state_n = READ;
          sel_n   = 1'b1;
          addr_n  = ADDR_DATA;
        end else begin
          state_n = DATA;
          if (avail) begin
            take    = 1'b1;
            rem_n   = rem - LEN_W'(1);
            sel_n   = 1'b1;
            rw_n    = 1'b1;
            addr_n  = ADDR_DATA;
            wdata_n = word;
          end
        end
      end
      READ: begin
        state_n = FIN;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      ctrl_q  <= '0;
      poly_q  <= '0;
      seed_q  <= '0;
      Sel     <= 1'b0;
      RW      <= 1'b0;
      addr    <= '0;
      data_wr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      Sel     <= sel_n;
      RW      <= rw_n;
      addr    <= addr_n;
      data_wr <= wdata_n;
      busy    <= busy_n;
      done    <= done_n;
      if (state == IDLE && start) begin
        ctrl_q <= cfg_ctrl;
        poly_q <= cfg_poly;
        seed_q <= cfg_seed;
      end
      if (state == READ) result <= data_rd;
    end
  end

endmodule
